// File: rtl/rbot_pkg.sv
// rtl/rbot_pkg.sv - shared face indices, move codes and sequencer state encoding
// Used by the move decoder and the move executor sequencer.
package rbot_pkg;

  localparam int NUM_FACES = 6;

  localparam logic [2:0] FACE_U = 3'd0;
  localparam logic [2:0] FACE_D = 3'd1;
  localparam logic [2:0] FACE_F = 3'd2;
  localparam logic [2:0] FACE_B = 3'd3;
  localparam logic [2:0] FACE_L = 3'd4;
  localparam logic [2:0] FACE_R = 3'd5;

  localparam logic [3:0] MOVE_NOP      = 4'd0;
  localparam logic [3:0] MOVE_CW_BASE  = 4'd1;
  localparam logic [3:0] MOVE_CCW_BASE = 4'd7;
  localparam logic [3:0] MOVE_CODE_END = 4'd13;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_STEP_LOW  = 3'd2,
    ST_STEP_HIGH = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

endpackage

// File: rtl/move_decode.sv
// rtl/move_decode.sv - combinational move code to (valid, face, clockwise) decoder
// Codes 1-6 are clockwise U..R, 7-12 counter-clockwise U..R, everything else is a no-op.
module move_decode
  import rbot_pkg::*;
(
  input  logic [3:0] code_i,
  output logic       valid_o,
  output logic [2:0] face_o,
  output logic       cw_o
);

  always_comb begin
    valid_o = 1'b0;
    face_o  = FACE_U;
    cw_o    = 1'b0;
    if (code_i >= MOVE_CW_BASE && code_i < MOVE_CCW_BASE) begin
      valid_o = 1'b1;
      face_o  = 3'(code_i - MOVE_CW_BASE);
      cw_o    = 1'b1;
    end else if (code_i >= MOVE_CCW_BASE && code_i < MOVE_CODE_END) begin
      valid_o = 1'b1;
      face_o  = 3'(code_i - MOVE_CCW_BASE);
      cw_o    = 1'b0;
    end
  end

endmodule

// File: rtl/move_executor.sv
// rtl/move_executor.sv - executes one quarter face turn as a step-pulse train
// All outputs are registered so step/dir/busy/move_done are glitch-free at the drivers.
module move_executor
  import rbot_pkg::*;
#(
  parameter int STEPS_PER_QUARTER = 50,
  parameter int HALF_PERIOD       = 50000,
  parameter int SETTLE_CYCLES     = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_move,
  input  logic [3:0] next_move,
  output logic       move_done,
  output logic       busy,
  output logic [5:0] step,
  output logic [5:0] dir
);

  // Counters are one value wider than their terminal count, so they never wrap.
  localparam int HW = $clog2(HALF_PERIOD + 1);
  localparam int SW = $clog2(STEPS_PER_QUARTER + 1);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  state_t        state_q, state_d;
  logic [3:0]    code_q, code_d;
  logic [2:0]    face_q, face_d;
  logic [5:0]    dir_q, dir_d;
  logic [5:0]    step_q, step_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic [HW-1:0] half_cnt_q, half_cnt_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  logic [CW-1:0] settle_cnt_q, settle_cnt_d;

  logic          dec_valid;
  logic [2:0]    dec_face;
  logic          dec_cw;

  move_decode u_decode (
    .code_i  (code_q),
    .valid_o (dec_valid),
    .face_o  (dec_face),
    .cw_o    (dec_cw)
  );

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    face_d       = face_q;
    dir_d        = dir_q;
    half_cnt_d   = half_cnt_q;
    step_cnt_d   = step_cnt_q;
    settle_cnt_d = settle_cnt_q;

    case (state_q)
      ST_IDLE: begin
        // done_q still high means this is the move_done cycle; requests there are dropped.
        if (start_move && !done_q) begin
          code_d  = next_move;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_valid) begin
          face_d           = dec_face;
          dir_d[dec_face]  = dec_cw;
          step_cnt_d       = SW'(STEPS_PER_QUARTER);
          half_cnt_d       = '0;
          state_d          = ST_STEP_LOW;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_STEP_LOW: begin
        if (half_cnt_q == HW'(HALF_PERIOD - 1)) begin
          half_cnt_d = '0;
          state_d    = ST_STEP_HIGH;
        end else begin
          half_cnt_d = half_cnt_q + 1'b1;
        end
      end
      ST_STEP_HIGH: begin
        if (half_cnt_q == HW'(HALF_PERIOD - 1)) begin
          half_cnt_d = '0;
          step_cnt_d = step_cnt_q - 1'b1;
          if (step_cnt_q == SW'(1)) begin
            settle_cnt_d = '0;
            state_d      = ST_SETTLE;
          end else begin
            state_d = ST_STEP_LOW;
          end
        end else begin
          half_cnt_d = half_cnt_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          settle_cnt_d = '0;
          state_d      = ST_DONE;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    step_d = (state_d == ST_STEP_HIGH) ? (6'd1 << face_d) : 6'd0;
    done_d = (state_q == ST_DONE);
    busy_d = (state_d != ST_IDLE) || done_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      code_q       <= MOVE_NOP;
      face_q       <= FACE_U;
      dir_q        <= '0;
      step_q       <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      half_cnt_q   <= '0;
      step_cnt_q   <= '0;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      face_q       <= face_d;
      dir_q        <= dir_d;
      step_q       <= step_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      half_cnt_q   <= half_cnt_d;
      step_cnt_q   <= step_cnt_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  assign step      = step_q;
  assign dir       = dir_q;
  assign move_done = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_move_executor.sv
// tb/tb_move_executor.sv - self-checking bench for move_executor
// Table vectors, hand-written reset sequence, then random codes against a rule-based model.
module tb_move_executor;

  localparam int HP       = 2;
  localparam int SPQ      = 3;
  localparam int SC       = 4;
  localparam int LAT_MOVE = 2 + 2 * HP * SPQ + SC;
  localparam int LAT_NOP  = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start_move = 1'b0;
  logic [3:0] next_move = 4'd0;
  logic       move_done;
  logic       busy;
  logic [5:0] step;
  logic [5:0] dir;

  int vectors = 0;
  int miscompares = 0;
  logic [5:0] exp_dir = 6'd0;

  typedef struct {
    logic [3:0] code;
    int         dup_at;
    logic [3:0] dup_code;
    logic [5:0] mask;
    logic       cw;
    int         lat;
  } vec_t;

  vec_t tbl[10];

  move_executor #(
    .STEPS_PER_QUARTER (SPQ),
    .HALF_PERIOD       (HP),
    .SETTLE_CYCLES     (SC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start_move (start_move),
    .next_move  (next_move),
    .move_done  (move_done),
    .busy       (busy),
    .step       (step),
    .dir        (dir)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Must be entered just after a falling edge; returns just after a falling edge.
  task automatic run_move(input string tag, input logic [3:0] code, input int dup_at,
                          input logic [3:0] dup_code, input logic [5:0] mask,
                          input logic cw, input int lat);
    int pulses[6];
    int done_cnt = 0, first_done = -1, width_bad = 0, hi_len = 0;
    int dir_bad = 0, busy_bad = 0, pulse_bad = 0;
    logic [5:0] prev = 6'd0;
    logic [5:0] new_dir;
    new_dir = exp_dir;
    for (int b = 0; b < 6; b++) begin
      pulses[b] = 0;
      if (mask[b]) new_dir[b] = cw;
    end
    start_move = 1'b1;
    next_move  = code;
    @(negedge clock);
    start_move = 1'b0;
    next_move  = 4'd0;
    for (int k = 0; k <= lat + 3; k++) begin
      for (int b = 0; b < 6; b++)
        if (step[b] && !prev[b]) pulses[b]++;
      if (step != 6'd0) hi_len++;
      else begin
        if (prev != 6'd0 && hi_len != HP) width_bad++;
        hi_len = 0;
      end
      prev = step;
      if (k >= 1 && dir !== new_dir) dir_bad++;
      if ((k <= lat) != (busy === 1'b1)) busy_bad++;
      if (move_done === 1'b1) begin
        done_cnt++;
        if (first_done < 0) first_done = k;
      end
      start_move = (k == dup_at);
      next_move  = (k == dup_at) ? dup_code : 4'd0;
      @(negedge clock);
    end
    start_move = 1'b0;
    next_move  = 4'd0;
    for (int b = 0; b < 6; b++)
      if (pulses[b] != (mask[b] ? SPQ : 0)) pulse_bad++;
    if (pulse_bad != 0)
      $display("  %s pulse counts U..R = %0d %0d %0d %0d %0d %0d", tag,
               pulses[0], pulses[1], pulses[2], pulses[3], pulses[4], pulses[5]);
    chk({tag, "_pulse_counts_bad"}, pulse_bad, 0);
    chk({tag, "_pulse_width_bad"}, width_bad, 0);
    chk({tag, "_done_latency"}, first_done, lat);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_dir_bad_cycles"}, dir_bad, 0);
    chk({tag, "_busy_bad_cycles"}, busy_bad, 0);
    chk({tag, "_dir_final"}, dir, new_dir);
    exp_dir = new_dir;
  endtask

  initial begin
    int rises, guard, stray_steps, stray_done, stray_busy;
    logic [5:0] prev;
    logic [3:0] code;
    logic [5:0] mask;
    logic       cw;
    int         lat, dup_at;

    tbl[0] = '{4'd1,  -1,       4'd0,  6'b000001, 1'b1, LAT_MOVE};
    tbl[1] = '{4'd12, -1,       4'd0,  6'b100000, 1'b0, LAT_MOVE};
    tbl[2] = '{4'd0,  -1,       4'd0,  6'b000000, 1'b0, LAT_NOP};
    tbl[3] = '{4'd14, -1,       4'd0,  6'b000000, 1'b0, LAT_NOP};
    tbl[4] = '{4'd1,  5,        4'd2,  6'b000001, 1'b1, LAT_MOVE};
    tbl[5] = '{4'd7,  LAT_MOVE, 4'd4,  6'b000001, 1'b0, LAT_MOVE};
    tbl[6] = '{4'd9,  -1,       4'd0,  6'b000100, 1'b0, LAT_MOVE};
    tbl[7] = '{4'd6,  1,        4'd11, 6'b100000, 1'b1, LAT_MOVE};
    tbl[8] = '{4'd13, 1,        4'd5,  6'b000000, 1'b0, LAT_NOP};
    tbl[9] = '{4'd15, LAT_NOP,  4'd3,  6'b000000, 1'b0, LAT_NOP};

    #1 reset = 1'b1;
    #1;
    chk("reset_step", step, 0);
    chk("reset_dir", dir, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", move_done, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("post_reset_step", step, 0);
    chk("post_reset_busy", busy, 0);

    for (int i = 0; i < 10; i++)
      run_move($sformatf("tbl%0d", i), tbl[i].code, tbl[i].dup_at, tbl[i].dup_code,
               tbl[i].mask, tbl[i].cw, tbl[i].lat);

    // Reset in the middle of the second step pulse of a U clockwise turn.
    start_move = 1'b1;
    next_move  = 4'd1;
    @(negedge clock);
    start_move = 1'b0;
    next_move  = 4'd0;
    rises = 0;
    guard = 0;
    prev  = 6'd0;
    while (rises < 2 && guard < 100) begin
      if (step[0] && !prev[0]) rises++;
      prev = step;
      guard++;
      @(negedge clock);
    end
    chk("abort_setup_rises", rises, 2);
    chk("abort_setup_step_high", step, 6'b000001);
    #2 reset = 1'b1;
    #1;
    chk("abort_async_step", step, 0);
    chk("abort_async_dir", dir, 0);
    chk("abort_async_busy", busy, 0);
    chk("abort_async_done", move_done, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_dir = 6'd0;
    stray_steps = 0;
    stray_done  = 0;
    stray_busy  = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (step != 6'd0) stray_steps++;
      if (move_done !== 1'b0) stray_done++;
      if (busy !== 1'b0) stray_busy++;
    end
    chk("abort_stray_steps", stray_steps, 0);
    chk("abort_stray_done", stray_done, 0);
    chk("abort_stray_busy", stray_busy, 0);
    run_move("after_abort", 4'd3, -1, 4'd0, 6'b000100, 1'b1, LAT_MOVE);

    // Random codes against a rule-based reference model.
    for (int i = 0; i < 12; i++) begin
      code = 4'($urandom_range(0, 15));
      if (code >= 4'd1 && code <= 4'd12) begin
        mask = 6'd1 << ((int'(code) - 1) % 6);
        cw   = (code <= 4'd6);
        lat  = 2 + 2 * HP * SPQ + SC;
      end else begin
        mask = 6'd0;
        cw   = 1'b0;
        lat  = 2;
      end
      dup_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, lat)) : -1;
      run_move($sformatf("rnd%0d_code%0d", i, code), code, dup_at,
               4'($urandom_range(0, 15)), mask, cw, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/move_executor.md
MOVE_EXECUTOR -- requirements
Module: move_executor

Interface
REQ-001 SHALL have parameter STEPS_PER_QUARTER, default 50, meaning step pulses per 90-degree face turn.
REQ-002 SHALL have parameter HALF_PERIOD, default 50000, meaning clock cycles per step-low and per step-high phase.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 1000000, meaning idle clock cycles after the last step before completion.
REQ-004 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start_move  input  1  one-cycle request to execute next_move.
REQ-007 SHALL have port next_move  input  4  move code, sampled with start_move.
REQ-008 SHALL have port move_done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port busy  output  1  high from the cycle after acceptance until the cycle after move_done.
REQ-010 SHALL have port step  output  6  per-motor step pulses; faces 0..5 = U,D,F,B,L,R.
REQ-011 SHALL have port dir  output  6  per-motor direction; 1 = clockwise.

Function
REQ-012 SHALL decode codes 1-6 as faces 0-5 clockwise, codes 7-12 as faces 0-5 counter-clockwise, and codes 0 and 13-15 as no-op.
REQ-013 SHALL implement FSM states IDLE, DECODE, STEP_LOW, STEP_HIGH, SETTLE, DONE.
REQ-014 SHALL accept start_move only in IDLE, capture next_move, and enter DECODE; start_move in any other state SHALL be ignored without queuing.
REQ-015 DECODE SHALL latch the face index and direction, drive dir[face], load the step counter with STEPS_PER_QUARTER, and enter STEP_LOW; a no-op SHALL go directly to DONE.
REQ-016 STEP_LOW SHALL hold all step bits at 0 for HALF_PERIOD cycles, then enter STEP_HIGH.
REQ-017 STEP_HIGH SHALL hold step[face]=1 and all other bits 0 for HALF_PERIOD cycles, then decrement the counter and enter SETTLE when the counter reaches 0, else STEP_LOW.
REQ-018 SETTLE SHALL hold step at 0 for SETTLE_CYCLES cycles, then enter DONE.
REQ-019 DONE SHALL assert move_done for exactly one cycle and return to IDLE.
REQ-020 A valid move SHALL produce exactly STEPS_PER_QUARTER rising edges on step[face] and none on any other bit.
REQ-021 move_done SHALL rise 2+2*HALF_PERIOD*STEPS_PER_QUARTER+SETTLE_CYCLES edges after the edge that sampled start_move; for a no-op, 2 edges.
REQ-022 dir SHALL remain constant from DECODE through DONE; dir bits of non-active faces SHALL hold their last value.
REQ-023 Phase counters SHALL be sized from their parameters via clog2 and SHALL never wrap; HALF_PERIOD, STEPS_PER_QUARTER and SETTLE_CYCLES SHALL each be at least 1.
REQ-024 start_move asserted in the same cycle as move_done SHALL be ignored; it SHALL be accepted from the following IDLE cycle.

Reset
REQ-025 Reset SHALL force state IDLE, step=0, dir=0, move_done=0, busy=0, and all counters to 0, immediately and regardless of the clock.
REQ-026 Reset mid-move SHALL abort the move with no move_done pulse, and no step pulse SHALL occur until a new start_move is accepted.

Structure
REQ-027 Face indices, move-code constants (NOP, CW base 1, CCW base 7) and the state encoding SHALL reside in shared package rbot_pkg, also used by the sequencing logic.
REQ-028 The move-code decoder (code -> valid, face, dir) SHALL be a combinational sub-module move_decode.

Verification (HALF_PERIOD=2, STEPS_PER_QUARTER=3, SETTLE_CYCLES=4)
REQ-029 start_move with next_move=1 -> dir[0]=1, exactly 3 pulses on step[0], each 2 cycles high, and move_done pulse 18 edges after acceptance.
REQ-030 next_move=12 -> dir[5]=0, 3 pulses on step[5] only, then move_done.
REQ-031 next_move=0, then next_move=14 -> step stays 0, move_done 2 edges after each acceptance.
REQ-032 second start_move (code 2) during busy -> ignored: only face-0 pulses and a single move_done.
REQ-033 reset asserted after the 2nd step pulse -> outputs zero asynchronously, no move_done; a subsequent start_move with code 3 executes a full 3-pulse move.
